// File: rtl/riscv_pkg.sv
// ============================================================================
// Package     : riscv_pkg
// Description : Shared RV32 constants for the execute-stage multiply/divide
//               unit: operand width, MDU op encodings, divider state encoding
//               and the RISC-V special-case result constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  // funct3[1:0] of the RV32M divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient for divide-by-zero, and the most negative signed value
  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_core_unsigned.sv
// ============================================================================
// Module      : div_core_unsigned
// Description : Iterative restoring unsigned divider datapath. One quotient
//               bit per step, MSB first. The next quotient/remainder values
//               are exposed combinationally so the caller can capture the
//               final result on the same edge as the last step.
// Revision    : 1.0 - initial release
// Ports       : i_clk, i_rst        clock, async active-high reset
//               i_load              capture operands, clear counter
//               i_step              perform one iteration
//               i_dividend/divisor  unsigned operands (sampled on i_load)
//               o_quo_next          quotient after the current step
//               o_rem_next          remainder after the current step
//               o_last              current step is the final one
// ============================================================================
`default_nettype none

module div_core_unsigned #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo_next,
  output logic [XLEN-1:0] o_rem_next,
  output logic            o_last
);

  logic [XLEN-1:0]  r_quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN:0]    w_rem_shift;
  logic [XLEN:0]    w_diff;
  logic             w_ge;

  // Trial subtract is XLEN+1 bits wide: the shifted partial remainder can
  // exceed XLEN bits, and the top bit of the difference is the borrow.
  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_div};
  assign w_ge        = ~w_diff[XLEN];

  assign o_rem_next  = w_ge ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
  assign o_quo_next  = {r_quo[XLEN-2:0], w_ge};
  assign o_last      = (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      r_quo <= o_quo_next;
      r_rem <= o_rem_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// Module      : mdu_divider
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Wraps the unsigned
//               iterative core with the control FSM, sign handling, RISC-V
//               special cases and the register-file write-back triple.
// Revision    : 1.0 - initial release
// Ports       : i_clk, i_rst            clock, async active-high reset
//               i_start                 request pulse (sampled in IDLE only)
//               i_op                    00 DIV, 01 DIVU, 10 REM, 11 REMU
//               i_rs1_data/i_rs2_data   dividend / divisor
//               i_rd_addr               destination register
//               i_kill                  abort (pipeline flush)
//               o_busy                  unit not idle; stalls the pipeline
//               o_valid                 one-cycle result strobe
//               o_result, o_rd_addr     write-back data / address
//               o_we                    write enable, never set for x0
// ============================================================================
`default_nettype none

module mdu_divider
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr,
  output logic            o_we
);

  div_state_t      r_state;
  logic            r_busy;
  logic            r_valid;
  logic            r_we;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;
  logic [4:0]      r_rd;      // destination of the operation in flight
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_signed;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_accept;
  logic            w_load;
  logic            w_step;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_rem_next;
  logic            w_last;
  logic [XLEN-1:0] w_calc_result;

  // Operand conditioning: signed ops divide magnitudes, unsigned ops pass raw
  assign w_signed = op_is_signed(i_op);
  assign w_s1     = w_signed & i_rs1_data[XLEN-1];
  assign w_s2     = w_signed & i_rs2_data[XLEN-1];
  assign w_abs1   = w_s1 ? -i_rs1_data : i_rs1_data;
  assign w_abs2   = w_s2 ? -i_rs2_data : i_rs2_data;

  assign w_div0   = (i_rs2_data == '0);
  assign w_ovf    = w_signed && (i_rs1_data == INT_MIN) && (i_rs2_data == DIV0_QUOT);

  // Kill wins over a simultaneous start
  assign w_accept = (r_state == IDLE) && i_start && !i_kill;
  assign w_load   = w_accept && !w_div0 && !w_ovf;
  assign w_step   = (r_state == CALC) && !i_kill;

  // Results that bypass the iterative datapath
  always_comb begin
    w_fast_result = '0;
    if (w_div0)
      w_fast_result = op_is_rem(i_op) ? i_rs1_data : DIV0_QUOT;
    else
      w_fast_result = op_is_rem(i_op) ? '0 : INT_MIN;
  end

  div_core_unsigned #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_abs1),
    .i_divisor  (w_abs2),
    .o_quo_next (w_quo_next),
    .o_rem_next (w_rem_next),
    .o_last     (w_last)
  );

  // Sign correction applied on the final step's combinational outputs
  assign w_calc_result = r_is_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                                  : (r_neg_q ? -w_quo_next : w_quo_next);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
      r_rd     <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd     <= i_rd_addr;
            r_is_rem <= op_is_rem(i_op);
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1;
            r_busy   <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_result <= w_fast_result;
              r_rd_out <= i_rd_addr;
              r_valid  <= 1'b1;
              r_we     <= (i_rd_addr != '0);
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (i_kill) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_result <= w_calc_result;
            r_rd_out <= r_rd;
            r_valid  <= 1'b1;
            r_we     <= (r_rd != '0);
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving while the result is on the bus must still squash the
  // write-back, so the strobes are qualified with the live kill.
  assign o_busy    = r_busy;
  assign o_valid   = r_valid & ~i_kill;
  assign o_we      = r_we & ~i_kill;
  assign o_result  = r_result;
  assign o_rd_addr = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_mdu_divider.sv
// ============================================================================
// Module      : tb_mdu_divider
// Description : Self-checking bench for mdu_divider. Directed stimulus pushes
//               hand-computed results into a scoreboard; a monitor pops and
//               compares on every o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_divider;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          st;    // cycle number of the start edge
    int          lat;   // edges from start edge to the edge raising o_valid
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          busy_cnt = 0;
  logic [31:0] rf [32];

  mdu_divider #(.XLEN(32), .CNT_W(5)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op       (op),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_rd_addr  (rd),
    .i_kill     (kill),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_result   (result),
    .o_rd_addr  (rd_out),
    .o_we       (we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Bench register file: writes whenever o_we, no x0 guard, so x0 stays
  // zero only if the unit never raises o_we for rd=0.
  always @(posedge clk) if (we) rf[rd_out] <= result;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got result 0x%08h rd %0d, expected no valid", result, rd_out);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_rd"}, 32'(rd_out), 32'(e.rd));
        chk({e.name, "_we"}, 32'(we), 32'(e.we));
        chk({e.name, "_latency"}, 32'(cyc - e.st), 32'(e.lat));
      end
    end
  end

  // Raise start at a negedge; caller lowers it
  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
  endtask

  task automatic issue_exp(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r,
                           input logic [31:0] res, input int lat);
    exp_t e;
    drive_start(o, a, b, r);
    e.res = res; e.rd = r; e.we = (r != 5'd0); e.st = cyc + 1; e.lat = lat; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int v0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; rd = '0; kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_valid",  32'(valid),  32'd0);
    chk("reset_we",     32'(we),     32'd0);
    chk("reset_result", result,      32'd0);
    chk("reset_rd",     32'(rd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal unsigned path, with busy-cycle accounting
    busy_cnt = 0;
    issue_exp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32);
    wait_idle();
    chk("divu_busy_cycles", 32'(busy_cnt), 32'd33);
    issue_exp("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 32);
    wait_idle();

    // Signed rules
    issue_exp("div_m7_2",  OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFD, 32);
    wait_idle();
    issue_exp("rem_m7_2",  OP_REM,  32'hFFFFFFF9, 32'd2,        5'd7, 32'hFFFFFFFF, 32);
    wait_idle();
    issue_exp("rem_7_m2",  OP_REM,  32'd7,        32'hFFFFFFFE, 5'd8, 32'd1,        32);
    wait_idle();
    issue_exp("div_m7_m2", OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 5'd8, 32'd3,        32);
    wait_idle();
    issue_exp("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1,       5'd9, 32'hFFFFFFFF, 32);
    wait_idle();

    // Fast paths: divide by zero and signed overflow
    busy_cnt = 0;
    issue_exp("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd3, 32'hFFFFFFFF, 0);
    wait_idle();
    chk("fast_busy_cycles", 32'(busy_cnt), 32'd1);
    issue_exp("remu_5_0",   OP_REMU, 32'd5,        32'd0,        5'd3, 32'd5,        0);
    wait_idle();
    issue_exp("div_m7_0",   OP_DIV,  32'hFFFFFFF9, 32'd0,        5'd3, 32'hFFFFFFFF, 0);
    wait_idle();
    issue_exp("rem_m7_0",   OP_REM,  32'hFFFFFFF9, 32'd0,        5'd3, 32'hFFFFFFF9, 0);
    wait_idle();
    issue_exp("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h80000000, 0);
    wait_idle();
    issue_exp("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd4, 32'd0,        0);
    wait_idle();

    // rd = x0: valid but no write enable
    issue_exp("divu_rd0", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32);
    wait_idle();
    chk("x0_reads_zero", rf[0], 32'd0);

    // Kill mid-CALC
    drive_start(OP_DIVU, 32'd100, 32'd7, 5'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    v0 = valid_cnt;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_to_idle", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_no_valid", 32'(valid_cnt - v0), 32'd0);
    issue_exp("after_kill", OP_DIVU, 32'd9, 32'd3, 5'd10, 32'd3, 32);
    wait_idle();

    // Start during CALC is ignored
    v0 = valid_cnt;
    issue_exp("divu_busy_start", OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 32);
    repeat (5) @(negedge clk);
    drive_start(OP_DIVU, 32'd9, 32'd3, 5'd12);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("calc_start_ignored", 32'(valid_cnt - v0), 32'd1);

    // Kill and start together in IDLE: request dropped
    v0 = valid_cnt;
    drive_start(OP_DIVU, 32'd9, 32'd3, 5'd12);
    kill = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    chk("kill_start_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("kill_start_idle_valid", 32'(valid_cnt - v0), 32'd0);

    // Asynchronous reset between edges mid-CALC
    drive_start(OP_DIVU, 32'd100, 32'd7, 5'd13);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    v0 = valid_cnt;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy",   32'(busy),   32'd0);
    chk("async_rst_valid",  32'(valid),  32'd0);
    chk("async_rst_we",     32'(we),     32'd0);
    chk("async_rst_result", result,      32'd0);
    chk("async_rst_rd",     32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("async_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    issue_exp("after_rst", OP_DIVU, 32'd9, 32'd3, 5'd14, 32'd3, 32);
    wait_idle();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage.
- Consumes the registerFile read ports (o_RD1 as dividend, o_RD2 as divisor).
- Produces a write-back triple (data, rd address, write enable) that drives registerFile i_WD3_data / i_A3_addr / WE3.
- The core stalls the pipeline on o_busy.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must equal clog2(XLEN).

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  request pulse; sampled only in IDLE
- i_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- i_rs1_data  in  XLEN  dividend (registerFile o_RD1)
- i_rs2_data  in  XLEN  divisor (registerFile o_RD2)
- i_rd_addr  in  5  destination register
- i_kill  in  1  abort the current operation (pipeline flush)
- o_busy  out  1  high whenever state != IDLE
- o_valid  out  1  one-cycle pulse, result ready
- o_result  out  XLEN  quotient or remainder, to i_WD3_data
- o_rd_addr  out  5  to i_A3_addr
- o_we  out  1  to WE3; equals o_valid && (o_rd_addr != 0)

Behaviour:
- One clock; reset is asynchronous and active-high.
  - i_rst forces state IDLE and clears all registered outputs and internal registers.
  - Reset values: o_busy=0, o_valid=0, o_we=0, o_result=0, o_rd_addr=0.
  - Reset mid-operation discards the operation; no o_valid is produced.
- States:
  - IDLE: i_start=1 at edge E0 latches op, rd, |rs1|, |rs2|, quotient sign and remainder sign (signed ops only; unsigned ops use raw operands).
    - Divisor == 0 or signed overflow: go directly to DONE.
    - Otherwise go to CALC with count=0.
  - CALC: restoring division, one quotient bit per edge, MSB first.
    - Remainder register is XLEN+1 bits; trial subtract each edge.
    - After XLEN iterations (E32 for XLEN=32), apply sign correction and register the result; go to DONE.
  - DONE: o_valid=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Normal case: o_valid is high in the cycle following E32, i.e. 32 cycles after the start edge.
  - Fast paths: o_valid is high in the cycle following E0.
  - Next i_start is accepted on the edge that leaves DONE+1 (IDLE); i_start in CALC/DONE is ignored, not queued.
- Sign rules:
  - Quotient negated when sign(rs1) XOR sign(rs2) for DIV.
  - Remainder takes the sign of rs1 for REM.
  - Unsigned ops use raw operands.
- Special cases, per RISC-V spec:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Register x0:
  - rd = 0 still produces o_valid=1, but o_we stays 0.
  - The unit never writes x0, backing the registerFile's hard-wired zero.
- i_kill:
  - In CALC or DONE: go to IDLE next edge; o_valid/o_we stay low.
  - In IDLE: no effect.
  - i_kill and i_start together in IDLE: kill wins; the request is dropped.
- o_result and o_rd_addr hold their last values outside o_valid; consumers qualify them with o_valid.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - MDU op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU)
  - divider state encoding (IDLE, CALC, DONE)
  - the constants DIV0_QUOT=all ones and INT_MIN=0x80000000
- One natural sub-module: div_core_unsigned.
  - Holds the iterative unsigned quotient/remainder datapath and counter, with load/step/done signals.
  - mdu_divider wraps it with the FSM, sign handling, special cases and write-back outputs.

Test Plan:
- DIVU 100/7, rd=5 -> o_busy high for 33 cycles; o_valid one cycle 32 cycles after start; o_result=14, o_rd_addr=5, o_we=1. Repeat with REMU -> o_result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/0xFFFFFFFE (-2) -> 1.
- DIVU 5/0 -> 0xFFFFFFFF one cycle after start; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 one cycle after start; REM -> 0.
- DIVU 100/7 with rd=0 -> o_valid=1, o_we=0. Then write through registerFile and read x0 -> 0.
- i_kill at cycle 10 of CALC -> IDLE next edge, no o_valid. A new start then completes correctly. i_start pulsed during CALC -> ignored, exactly one o_valid.
- i_rst asserted asynchronously between clock edges mid-CALC -> all outputs 0 immediately. After release, DIVU 9/3 -> 3.
